// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - AHB-Lite microcode sequencer driving a GPIO output bank
// Fetches words from the microcode RAM read port and executes OUT/WAIT/WAITIN/HALT.
module microcode_sequencer #(
  parameter int ADDR_W = 8,
  parameter int GPIO_W = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [31:0]       HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [31:0]       HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [31:0]       HRDATA,
  output logic [ADDR_W-1:0] mc_addr,
  output logic              mc_ren,
  input  logic [31:0]       mc_rdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_WAITIN, S_DONE
  } state_t;

  localparam logic [1:0] OP_OUT    = 2'b00;
  localparam logic [1:0] OP_WAIT   = 2'b01;
  localparam logic [1:0] OP_WAITIN = 2'b10;
  localparam logic [1:0] OP_HALT   = 2'b11;

  localparam logic [1:0] REG_START = 2'd0;
  localparam logic [1:0] REG_END   = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_GPIO  = 2'd3;

  state_t            state, state_next;
  logic [ADDR_W-1:0] start_addr, end_addr, pc;
  logic              loop, done, busy;
  logic [23:0]       counter;
  logic [GPIO_W-1:0] sync1, gpio_sync;
  logic [1:0]        bus_addr;
  logic              bus_wr, bus_rd;
  logic [3:0]        wi_idx;
  logic              wi_val;
  logic              ctrl_wr, run_cmd, abort_cmd;
  logic [1:0]        op;
  logic [23:0]       wait_n;
  logic [3:0]        sel_idx;
  logic              sel_val, in_bit, cond, adv, seq_end;
  logic              unused_ok;

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE,
                       HWDATA[31:ADDR_W], mc_rdata[29:24]};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      bus_addr <= '0;
      bus_wr   <= 1'b0;
      bus_rd   <= 1'b0;
    end else begin
      bus_wr <= HSEL && HTRANS[1] && HREADY && HWRITE;
      bus_rd <= HSEL && HTRANS[1] && HREADY && !HWRITE;
      if (HSEL && HTRANS[1] && HREADY) bus_addr <= HADDR[3:2];
    end
  end

  assign ctrl_wr   = bus_wr && (bus_addr == REG_CTRL);
  assign run_cmd   = ctrl_wr && HWDATA[0] && !busy;
  assign abort_cmd = ctrl_wr && !HWDATA[0] && busy;

  assign op     = mc_rdata[31:30];
  assign wait_n = mc_rdata[23:0];

  // In EXEC the condition comes straight from the word; in WAITIN from the latched copy.
  assign sel_idx = (state == S_EXEC) ? mc_rdata[3:0] : wi_idx;
  assign sel_val = (state == S_EXEC) ? mc_rdata[4]   : wi_val;

  always_comb begin
    in_bit = 1'b0;
    for (int i = 0; i < GPIO_W; i++)
      if (i < 16 && sel_idx == 4'(i)) in_bit = gpio_sync[i];
  end

  assign cond = (in_bit == sel_val);

  always_comb begin
    adv = 1'b0;
    case (state)
      S_EXEC:   adv = (op == OP_OUT) || (op == OP_WAIT && wait_n == '0) ||
                      (op == OP_WAITIN && cond);
      S_WAIT:   adv = (counter == '0);
      S_WAITIN: adv = cond;
      default:  adv = 1'b0;
    endcase
  end

  assign seq_end = adv && (pc == end_addr) && !loop;

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (run_cmd) state_next = S_FETCH;
      S_DONE:  state_next = run_cmd ? S_FETCH : S_IDLE;
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        if (op == OP_HALT)      state_next = S_DONE;
        else if (adv)           state_next = seq_end ? S_DONE : S_FETCH;
        else if (op == OP_WAIT) state_next = S_WAIT;
        else                    state_next = S_WAITIN;
      end
      S_WAIT, S_WAITIN: if (adv) state_next = seq_end ? S_DONE : S_FETCH;
      default: state_next = S_IDLE;
    endcase
    if (abort_cmd) state_next = S_IDLE;
  end

  always_comb begin
    mc_ren  = (state == S_FETCH);
    mc_addr = pc;
    busy    = !(state == S_IDLE || state == S_DONE);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      start_addr <= '0;
      end_addr   <= '0;
      loop       <= 1'b0;
      done       <= 1'b0;
      pc         <= '0;
      counter    <= '0;
      gpio_out   <= '0;
      sync1      <= '0;
      gpio_sync  <= '0;
      wi_idx     <= '0;
      wi_val     <= 1'b0;
    end else begin
      sync1     <= gpio_in;
      gpio_sync <= sync1;
      if (bus_wr && bus_addr == REG_START && !busy) start_addr <= HWDATA[ADDR_W-1:0];
      if (bus_wr && bus_addr == REG_END && !busy)   end_addr   <= HWDATA[ADDR_W-1:0];
      if (ctrl_wr) loop <= HWDATA[1];
      if (run_cmd) begin
        done <= 1'b0;
        pc   <= start_addr;
      end else if (!abort_cmd) begin
        if (state == S_EXEC) begin
          if (op == OP_OUT) gpio_out <= mc_rdata[GPIO_W-1:0];
          if (op == OP_WAIT && wait_n != '0) counter <= wait_n - 24'd1;
          wi_idx <= mc_rdata[3:0];
          wi_val <= mc_rdata[4];
        end else if (state == S_WAIT && counter != '0) begin
          counter <= counter - 24'd1;
        end
        if (adv && pc != end_addr) pc <= pc + ADDR_W'(1);
        else if (adv && loop)      pc <= start_addr;
        if (state_next == S_DONE) done <= 1'b1;
      end
    end
  end

  // Read data is driven during the data phase from the already-updated registers.
  always_comb begin
    HRDATA = '0;
    if (bus_rd) begin
      case (bus_addr)
        REG_START: HRDATA = 32'(start_addr);
        REG_END:   HRDATA = 32'(end_addr);
        REG_CTRL:  HRDATA = {29'b0, done, loop, busy};
        default:   HRDATA = 32'(gpio_sync);
      endcase
    end
  end

endmodule
